// File: rtl/dsp_sample_buffer_pkg.sv
// Register map, bit positions and reset constants shared by the sample buffer and its bench.
package dsp_sample_buffer_defs;

    typedef enum logic [1:0] {
        REG_DATA      = 2'd0,
        REG_STATUS    = 2'd1,
        REG_CONTROL   = 2'd2,
        REG_THRESHOLD = 2'd3
    } reg_sel_e;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_STALL     = 2;
    localparam int ST_IRQ       = 3;
    localparam int ST_LEVEL_LSB = 8;

    localparam int CTL_ENABLE = 0;
    localparam int CTL_FLUSH  = 1;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic RST_STALL  = 1'b0;

endpackage

// File: rtl/dsp_sample_buffer_if.sv
// Wishbone classic slave bus plus the streaming sample input and level interrupt.
interface dsp_sample_buffer_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic [aw-1:0] wb_adr_i;
    logic [dw-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [dw-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;
    logic          s_valid;
    logic [dw-1:0] s_data;
    logic          s_ready;
    logic          level_irq;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
        input  s_valid, s_data,
        output s_ready, level_irq
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
        output s_valid, s_data,
        input  s_ready, level_irq
    );

endinterface

// File: rtl/dsp_sample_buffer_fifo.sv
// Synchronous FIFO: push/pop visible at the next edge; flush wins over a coincident push.
// Caller must not push when full or pop when empty; both are also guarded here.
module dsp_sync_fifo #(
    parameter int dw         = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [dw-1:0]         wdata_i,
    output logic [dw-1:0]         rdata_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);
    import dsp_sample_buffer_defs::*;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [dw-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) level_d = level_q + 1'b1;
            if (pop_ok && !push_ok) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dsp_sample_buffer.sv
// Wishbone-polled sample FIFO: one-cycle registered ack/err per access, one access per 2 cycles.
// Producer is backpressured via s_ready (enable & !full); overrun attempts set the sticky stall bit.
module dsp_sample_buffer #(
    parameter int            dw            = 32,
    parameter int            aw            = 32,
    parameter int            DEPTH_LOG2    = 4,
    parameter logic [aw-1:0] SLAVE_ADDRESS = '0
) (
    input logic                wb_clk,
    input logic                wb_rst,
    dsp_sample_buffer_if.slave bus
);
    import dsp_sample_buffer_defs::*;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic                ack_q, ack_d, err_q, err_d;
    logic [dw-1:0]       dat_q, dat_d;
    logic                enable_q, enable_d;
    logic                stall_q, stall_d;
    logic [DEPTH_LOG2:0] threshold_q, threshold_d;
    logic                stall_clr, pop, flush, push;
    logic                full, empty, req, hit, irq;
    logic [dw-1:0]       head, status;
    logic [DEPTH_LOG2:0] level;
    reg_sel_e            reg_sel;
    logic                unused_ok;

    assign unused_ok = ^{bus.wb_sel_i, bus.wb_cti_i, bus.wb_bte_i, bus.wb_adr_i[1:0], bus.wb_dat_i};

    assign hit     = (bus.wb_adr_i[aw-1:4] == SLAVE_ADDRESS[aw-1:4]);
    assign req     = bus.wb_cyc_i && bus.wb_stb_i && hit && !ack_q && !err_q;
    assign reg_sel = reg_sel_e'(bus.wb_adr_i[3:2]);

    assign bus.s_ready   = enable_q && !full;
    assign push          = bus.s_valid && bus.s_ready;
    assign irq           = enable_q && (level >= threshold_q);
    assign bus.level_irq = irq;

    always_comb begin
        status                             = '0;
        status[ST_EMPTY]                   = empty;
        status[ST_FULL]                    = full;
        status[ST_STALL]                   = stall_q;
        status[ST_IRQ]                     = irq;
        status[ST_LEVEL_LSB +: 8]          = 8'(level);
    end

    always_comb begin
        ack_d       = 1'b0;
        err_d       = 1'b0;
        dat_d       = '0;
        pop         = 1'b0;
        flush       = 1'b0;
        stall_clr   = 1'b0;
        enable_d    = enable_q;
        threshold_d = threshold_q;
        if (req) begin
            unique case (reg_sel)
                REG_DATA: begin
                    // Reading an empty FIFO or writing DATA is a bus error, not a stale value.
                    if (!bus.wb_we_i && !empty) begin
                        ack_d = 1'b1;
                        dat_d = head;
                        pop   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                REG_STATUS: begin
                    ack_d = 1'b1;
                    if (bus.wb_we_i) stall_clr = bus.wb_dat_i[ST_STALL];
                    else             dat_d     = status;
                end
                REG_CONTROL: begin
                    ack_d = 1'b1;
                    if (bus.wb_we_i) begin
                        enable_d = bus.wb_dat_i[CTL_ENABLE];
                        flush    = bus.wb_dat_i[CTL_FLUSH];
                    end else begin
                        dat_d[CTL_ENABLE] = enable_q;
                    end
                end
                REG_THRESHOLD: begin
                    ack_d = 1'b1;
                    if (bus.wb_we_i) threshold_d = bus.wb_dat_i[DEPTH_LOG2:0];
                    else             dat_d[DEPTH_LOG2:0] = threshold_q;
                end
                default: ;
            endcase
        end
        stall_d = (stall_q && !stall_clr) || (bus.s_valid && enable_q && full);
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            enable_q    <= RST_ENABLE;
            stall_q     <= RST_STALL;
            threshold_q <= (DEPTH_LOG2+1)'(DEPTH);
        end else begin
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
            enable_q    <= enable_d;
            stall_q     <= stall_d;
            threshold_q <= threshold_d;
        end
    end

    assign bus.wb_dat_o = dat_q;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.wb_rty_o = 1'b0;

    dsp_sync_fifo #(
        .dw         (dw),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (wb_clk),
        .rst     (wb_rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (bus.s_data),
        .rdata_o (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule
